addsub_pipe: RTL

Parametrised, registered saturating add/subtract unit; successor to the combinational 16-bit addsub for the execute stage. Supports four modes: full-width ADD, full-width SUB, lane-parallel PADD, and multi-cycle byte-chunk reduction RED. Operands enter through a valid/ready handshake, and results leave through one. RED is sequenced by an internal FSM, so the EX stage can stall on in_ready.

---
 rtl/addsub_pkg.sv | 49 ++++
 rtl/addsub_pipe_sat_lane.sv | 22 ++
 rtl/addsub_pipe.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/addsub_pkg.sv
// Shared types and the width-generic saturating add helper for addsub_pipe.
package addsub_pkg;

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_SUB  = 2'b01,
        OP_PADD = 2'b10,
        OP_RED  = 2'b11
    } op_e;

    typedef enum logic {
        IDLE    = 1'b0,
        RED_ACC = 1'b1
    } state_e;

    localparam int unsigned SAT_MAXW = 64;

    // sat sits in the LSB so callers can take the low (w+1) bits as {sum, sat}.
    typedef struct packed {
        logic [SAT_MAXW-1:0] sum;
        logic                sat;
    } sat_res_t;

    // Operands arrive sign-extended to SAT_MAXW; w is the logical width (w <= SAT_MAXW-2).
    function automatic sat_res_t sat_add(
        input logic signed [SAT_MAXW-1:0] x,
        input logic signed [SAT_MAXW-1:0] y,
        input logic                       cin,
        input int unsigned                w
    );
        logic signed [SAT_MAXW-1:0] full;
        logic signed [SAT_MAXW-1:0] hi;
        logic signed [SAT_MAXW-1:0] lo;
        sat_res_t r;
        full = x + y + signed'({{(SAT_MAXW-1){1'b0}}, cin});
        hi   = signed'((SAT_MAXW'(1) << (w - 1)) - SAT_MAXW'(1));
        lo   = ~hi;
        r.sat = (full > hi) || (full < lo);
        if (full > hi) begin
            r.sum = hi;
        end else if (full < lo) begin
            r.sum = lo;
        end else begin
            r.sum = full;
        end
        return r;
    endfunction

endpackage

// File: rtl/addsub_pipe_sat_lane.sv
// Combinational signed saturating adder: sum = sat(a + b + cin) at width W.
module sat_lane
    import addsub_pkg::*;
#(
    parameter int unsigned W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         sat
);

    logic signed [SAT_MAXW-1:0] xa;
    logic signed [SAT_MAXW-1:0] xb;

    assign xa = {{(SAT_MAXW-W){a[W-1]}}, a};
    assign xb = {{(SAT_MAXW-W){b[W-1]}}, b};

    assign {sum, sat} = (W+1)'(sat_add(xa, xb, cin, W));

endmodule

// File: rtl/addsub_pipe.sv
// Registered saturating add/sub unit: ADD, SUB, lane-parallel PADD and multi-cycle
// byte-chunk reduction RED, with valid/ready on both sides.
module addsub_pipe
    import addsub_pkg::*;
#(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned LANE_W = 4,
    parameter int unsigned RED_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             ovf,
    output logic             zero,
    output logic             neg
);

    localparam int unsigned NCHUNK = WIDTH / RED_W;
    localparam int unsigned NLANE  = WIDTH / LANE_W;
    localparam int unsigned ACC_W  = RED_W + $clog2(2 * NCHUNK) + 1;
    localparam int unsigned CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NCHUNK - 1);

    state_e state, state_nx;
    op_e    opc;

    logic                    out_free;
    logic                    accept;
    logic                    red_step;
    logic                    red_done;
    logic [CNT_W-1:0]        cnt;
    logic [WIDTH-1:0]        a_r, b_r;
    logic signed [ACC_W-1:0] acc, acc_nx;
    logic [WIDTH-1:0]        full_b, full_sum, lane_sum, alu_s, red_s;
    logic                    full_sat, alu_ovf;
    logic [NLANE-1:0]        lane_sat;

    assign opc      = op_e'(op);
    assign out_free = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept && opc == OP_RED) state_nx = RED_ACC;
            RED_ACC: if (red_done) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // The final RED step stalls in place until the output register is free.
    always_comb begin
        in_ready = 1'b0;
        red_step = 1'b0;
        red_done = 1'b0;
        case (state)
            IDLE: in_ready = out_free;
            RED_ACC: begin
                red_done = (cnt == LAST) && out_free;
                red_step = (cnt != LAST) || out_free;
            end
            default: ;
        endcase
    end

    // SUB reuses the full-width adder as a + ~b + 1.
    assign full_b = (opc == OP_SUB) ? ~b : b;

    sat_lane #(.W(WIDTH)) u_full (
        .a   (a),
        .b   (full_b),
        .cin (opc == OP_SUB),
        .sum (full_sum),
        .sat (full_sat)
    );

    for (genvar i = 0; i < int'(NLANE); i++) begin : g_lane
        sat_lane #(.W(LANE_W)) u_lane (
            .a   (a[i*LANE_W +: LANE_W]),
            .b   (b[i*LANE_W +: LANE_W]),
            .cin (1'b0),
            .sum (lane_sum[i*LANE_W +: LANE_W]),
            .sat (lane_sat[i])
        );
    end

    assign alu_s   = (opc == OP_PADD) ? lane_sum : full_sum;
    assign alu_ovf = (opc == OP_PADD) ? |lane_sat : full_sat;

    assign acc_nx = acc + ACC_W'(signed'(a_r[RED_W-1:0])) + ACC_W'(signed'(b_r[RED_W-1:0]));
    assign red_s  = WIDTH'(acc_nx);

    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
            cnt <= '0;
            a_r <= '0;
            b_r <= '0;
        end else if (accept && opc == OP_RED) begin
            acc <= '0;
            cnt <= '0;
            a_r <= a;
            b_r <= b;
        end else if (red_step) begin
            acc <= acc_nx;
            cnt <= cnt + CNT_W'(1);
            a_r <= a_r >> RED_W;
            b_r <= b_r >> RED_W;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            s         <= '0;
            ovf       <= 1'b0;
            zero      <= 1'b0;
            neg       <= 1'b0;
        end else if (red_done) begin
            out_valid <= 1'b1;
            s         <= red_s;
            ovf       <= 1'b0;
            zero      <= (red_s == '0);
            neg       <= red_s[WIDTH-1];
        end else if (accept && opc != OP_RED) begin
            out_valid <= 1'b1;
            s         <= alu_s;
            ovf       <= alu_ovf;
            zero      <= (alu_s == '0);
            neg       <= alu_s[WIDTH-1];
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
